// File: rtl/symbol_feeder.sv
// Byte-to-symbol feeder: buffers bytes in a small FIFO and serializes each into four 2-bit
// symbols, one per clock, driving the idle symbol 2'b00 whenever no data is available.
module symbol_feeder #(
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_byte_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [1:0] num_o,
  output logic       num_valid_o,
  output logic       num_first_o,
  output logic       busy_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    shreg_q;
  logic [2:0]    left_q;
  state_e        state_q;
  logic [1:0]    num_q;
  logic          num_valid_q;
  logic          num_first_q;

  logic          push;
  logic          pop;
  logic [7:0]    head;

  function automatic logic [1:0] emit_sym(input logic [7:0] b);
    return MSB_FIRST ? b[7:6] : b[1:0];
  endfunction

  function automatic logic [7:0] shift2(input logic [7:0] b);
    return MSB_FIRST ? {b[5:0], 2'b00} : {2'b00, b[7:2]};
  endfunction

  // Full check uses the pre-edge count only, so a same-edge pop never frees a slot.
  assign in_ready_o = (count_q != FullCount);
  assign push       = in_valid_i && in_ready_o;
  assign pop        = (state_q == StIdle) && (count_q != '0);
  assign head       = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= in_byte_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      left_q      <= '0;
      num_q       <= 2'b00;
      num_valid_q <= 1'b0;
      num_first_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            num_q       <= emit_sym(head);
            shreg_q     <= shift2(head);
            left_q      <= 3'd3;
            num_valid_q <= 1'b1;
            num_first_q <= 1'b1;
            state_q     <= StShift;
          end else begin
            num_q       <= 2'b00;
            num_valid_q <= 1'b0;
            num_first_q <= 1'b0;
          end
        end
        StShift: begin
          num_q       <= emit_sym(shreg_q);
          shreg_q     <= shift2(shreg_q);
          left_q      <= left_q - 3'd1;
          num_valid_q <= 1'b1;
          num_first_q <= 1'b0;
          if (left_q == 3'd1) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign num_o       = num_q;
  assign num_valid_o = num_valid_q;
  assign num_first_o = num_first_q;
  assign busy_o      = (count_q != '0) || (left_q != 3'd0);

endmodule

// File: tb/tb_symbol_feeder.sv
// Directed bench for symbol_feeder: reset, single/back-to-back bytes, overflow, LSB-first
// ordering and asynchronous reset mid-byte.
module tb_symbol_feeder;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_byte;
  logic       in_valid;

  logic       in_ready, num_valid, num_first, busy;
  logic [1:0] num;
  logic       l_in_ready, l_num_valid, l_num_first, l_busy;
  logic [1:0] l_num;

  int checks   = 0;
  int failures = 0;

  symbol_feeder #(.DEPTH(4), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_byte_i  (in_byte),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .num_o      (num),
    .num_valid_o(num_valid),
    .num_first_o(num_first),
    .busy_o     (busy)
  );

  symbol_feeder #(.DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_byte_i  (in_byte),
    .in_valid_i (in_valid),
    .in_ready_o (l_in_ready),
    .num_o      (l_num),
    .num_valid_o(l_num_valid),
    .num_first_o(l_num_first),
    .busy_o     (l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] sym_a [8];
  logic [1:0] sym_l [4];
  int         sent;
  int         got;
  int         nsym;
  logic [7:0] asm_byte;
  logic       acc;

  initial begin
    sym_a = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b10};
    sym_l = '{2'b11, 2'b11, 2'b10, 2'b01};

    // Reset held with in_valid asserted and clock running.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_byte  = 8'hAA;
    tick(); tick(); tick();
    chk("rst_num", 8'(num), 8'h0);
    chk("rst_num_valid", 8'(num_valid), 8'h0);
    chk("rst_in_ready", 8'(in_ready), 8'h1);
    chk("rst_busy", 8'(busy), 8'h0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    chk("post_rst_busy", 8'(busy), 8'h0);
    chk("post_rst_num_valid", 8'(num_valid), 8'h0);

    // Single byte 0x6F.
    in_valid = 1'b1;
    in_byte  = 8'h6F;
    tick();
    in_valid = 1'b0;
    chk("single_k_num_valid", 8'(num_valid), 8'h0);
    chk("single_k_busy", 8'(busy), 8'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("single_sym%0d", i), 8'(num), 8'(sym_a[i]));
      chk($sformatf("single_valid%0d", i), 8'(num_valid), 8'h1);
      chk($sformatf("single_first%0d", i), 8'(num_first), (i == 0) ? 8'h1 : 8'h0);
    end
    chk("single_busy_end", 8'(busy), 8'h0);
    tick();
    chk("single_idle_num", 8'(num), 8'h0);
    chk("single_idle_valid", 8'(num_valid), 8'h0);

    // Back-to-back 0x6F, 0xBE.
    in_valid = 1'b1;
    in_byte  = 8'h6F;
    tick();
    in_byte = 8'hBE;
    for (int i = 0; i < 8; i++) begin
      tick();
      in_valid = 1'b0;
      chk($sformatf("b2b_sym%0d", i), 8'(num), 8'(sym_a[i]));
      chk($sformatf("b2b_valid%0d", i), 8'(num_valid), 8'h1);
      chk($sformatf("b2b_first%0d", i), 8'(num_first), (i == 0 || i == 4) ? 8'h1 : 8'h0);
    end
    tick();
    chk("b2b_idle_valid", 8'(num_valid), 8'h0);
    chk("b2b_idle_busy", 8'(busy), 8'h0);

    // Overflow: offer 0x01..0x08 continuously, holding each byte until accepted.
    sent     = 0;
    got      = 0;
    nsym     = 0;
    asm_byte = '0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      in_valid = (sent < 8);
      in_byte  = 8'(sent + 1);
      acc      = in_valid && in_ready;
      tick();
      if (acc) sent++;
      if (cyc == 3) chk("ovf_ready_c3", 8'(in_ready), 8'h1);
      if (cyc == 4) chk("ovf_full_c4", 8'(in_ready), 8'h0);
      if (cyc == 5) chk("ovf_reassert_c5", 8'(in_ready), 8'h1);
      if (cyc == 7) chk("ovf_full_c7", 8'(in_ready), 8'h0);
      if (num_valid) begin
        if (num_first) chk("ovf_first_align", 8'(nsym), 8'h0);
        asm_byte = {asm_byte[5:0], num};
        nsym++;
        if (nsym == 4) begin
          got++;
          chk($sformatf("ovf_byte%0d", got), asm_byte, 8'(got));
          nsym = 0;
        end
      end
    end
    in_valid = 1'b0;
    chk("ovf_sent", 8'(sent), 8'd8);
    chk("ovf_got", 8'(got), 8'd8);
    chk("ovf_busy_end", 8'(busy), 8'h0);

    // LSB-first ordering.
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'h6F;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("lsb_sym%0d", i), 8'(l_num), 8'(sym_l[i]));
      chk($sformatf("lsb_first%0d", i), 8'(l_num_first), (i == 0) ? 8'h1 : 8'h0);
    end
    tick();
    chk("lsb_idle_valid", 8'(l_num_valid), 8'h0);

    // Asynchronous reset after 2nd symbol of 0xFF with two bytes queued.
    in_valid = 1'b1;
    in_byte  = 8'hFF;
    tick();
    in_byte = 8'hAA;
    tick();
    in_byte = 8'h55;
    tick();
    in_valid = 1'b0;
    chk("ar_pre_num", 8'(num), 8'h3);
    chk("ar_pre_first", 8'(num_first), 8'h0);
    chk("ar_pre_busy", 8'(busy), 8'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_num", 8'(num), 8'h0);
    chk("ar_num_valid", 8'(num_valid), 8'h0);
    chk("ar_busy", 8'(busy), 8'h0);
    chk("ar_in_ready", 8'(in_ready), 8'h1);
    rst_n = 1'b1;
    tick();
    chk("ar_release_valid", 8'(num_valid), 8'h0);
    in_valid = 1'b1;
    in_byte  = 8'h55;
    tick();
    in_valid = 1'b0;
    chk("ar_k_valid", 8'(num_valid), 8'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ar_sym%0d", i), 8'(num), 8'h1);
      chk($sformatf("ar_valid%0d", i), 8'(num_valid), 8'h1);
    end
    tick();
    chk("ar_idle_num", 8'(num), 8'h0);
    chk("ar_idle_valid", 8'(num_valid), 8'h0);
    tick();
    chk("ar_no_stale", 8'(num_valid), 8'h0);
    chk("ar_busy_end", 8'(busy), 8'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
